shift_seq_unit: RTL and testbench

- Multicycle shift execution unit for the MIPS multicycle datapath.
- Consumes the operand and shift amount chosen by the shifter-source and shift-amount muxes (data from A, B or the extended immediate; amount from B[4:0], shamt or 16).
- Performs the shift iteratively, one bit per cycle, under a start/busy/done handshake.
- Drives the shifter result back into the datapath write-back mux, and lets the control FSM stall until done.

---
 rtl/shift_seq_unit.sv | 185 ++++++++++++++++++
 tb/tb_shift_seq_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// ---------------------------------------------------------------------------
// shift_seq_unit
//
// Multicycle shift execution unit for the MIPS multicycle datapath. The
// operand comes from the shifter-source mux (A, B or extended immediate) and
// the amount from the shift-amount mux (B[4:0], shamt or 16 for lui). The
// shift is performed iteratively under a start/busy/done handshake so the
// control FSM can stall on busy and resume when done pulses.
//
// Parameters:
//   WIDTH    operand/result width in bits (default 32)
//   SHAMT_W  shift-amount width, 2**SHAMT_W must equal WIDTH (default 5)
//
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   synchronous active-high reset, aborts any shift in flight
//   start     in   request pulse, only accepted in IDLE or DONE
//   op        in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in   in   operand, captured on acceptance
//   shamt_in  in   shift amount, captured on acceptance
//   busy      out  high for every cycle spent in SHIFT
//   done      out  one-cycle pulse, result is valid
//   result    out  shifted value, held until the next accepted start
//
// Optional feature (macro SHIFT_SEQ_STEP4_EN):
//   When defined, SHIFT advances 4 bit positions per edge while at least 4
//   remain and 1 bit per edge otherwise, so an amount N completes in
//   floor(N/4) + (N mod 4) + 1 cycles instead of N + 1. Results are the
//   same in both builds; only the busy/done timing differs.
// ---------------------------------------------------------------------------
module shift_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    state_t             state;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] count;

    logic [WIDTH-1:0]   step_val;
    logic [SHAMT_W-1:0] step_cnt;

    // One bit position of the selected operation. The fill bit is what
    // distinguishes the four ops: zero for the logical shifts, the sign bit
    // for SRA and the bit falling off the LSB for ROR.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [1:0]       opv,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (opv)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_STEP4_EN
    localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);

    // Four bit positions at once. Must match four consecutive applications
    // of shift_one so that both builds produce identical results.
    function automatic logic [WIDTH-1:0] shift_four(
        input logic [1:0]       opv,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (opv)
            OP_SLL:  r = {v[WIDTH-5:0], 4'b0000};
            OP_SRL:  r = {4'b0000, v[WIDTH-1:4]};
            OP_SRA:  r = {{4{v[WIDTH-1]}}, v[WIDTH-1:4]};
            OP_ROR:  r = {v[3:0], v[WIDTH-1:4]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Next value of result/count for one SHIFT edge. Large strides are taken
    // while four or more positions remain; the tail is finished one bit at a
    // time so any amount lands exactly on zero.
    always_comb begin
        step_val = shift_one(op_q, result);
        step_cnt = count - CNT_ONE;
        if (count >= CNT_FOUR) begin
            step_val = shift_four(op_q, result);
            step_cnt = count - CNT_FOUR;
        end
    end
`else
    // Next value of result/count for one SHIFT edge: a single bit position
    // per clock, so an amount N takes exactly N SHIFT cycles.
    always_comb begin
        step_val = shift_one(op_q, result);
        step_cnt = count - CNT_ONE;
    end
`endif

    // Control FSM with registered busy/done. The operands are captured only
    // when a start is accepted (IDLE or DONE), which is what lets the
    // datapath muxes move on while the shift is still running. busy and done
    // are assigned from the state being entered, so they line up with the
    // state register and can never be high together. A zero amount skips
    // SHIFT entirely and goes straight to DONE with the operand unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            count  <= CNT_ZERO;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_q   <= op;
                        result <= data_in;
                        count  <= shamt_in;
                        if (shamt_in == CNT_ZERO) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    result <= step_val;
                    count  <= step_cnt;
                    if (step_cnt == CNT_ZERO) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_unit
//
// Self-checking bench for shift_seq_unit. The driver issues directed
// vectors with hand-computed results and pushes the expectation (result,
// cycles from acceptance to done, busy cycle count) into a scoreboard queue.
// An independent monitor pops and compares whenever done pulses.
// Honors SHIFT_SEQ_STEP4_EN for the expected timing.
// ---------------------------------------------------------------------------
module tb_shift_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          delta;
        int          accept;
        int          id;
    } sb_item_t;

    sb_item_t sbQueue[$];

    int checks     = 0;
    int errors     = 0;
    int cycleCount = 0;
    int busyCnt    = 0;

    shift_seq_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt_in (shamt_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure acceptance-to-done latency.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Hard stop so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Cycles between the accepting edge and the cycle in which done is
    // high; also the number of busy cycles.
    function automatic int expDelta(input int n);
`ifdef SHIFT_SEQ_STEP4_EN
        return (n / 4) + (n % 4);
`else
        return n;
`endif
    endfunction

    // Single comparison with reporting.
    task automatic checkOutput(input string name, input int id,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vec %0d): got 0x%08h, expected 0x%08h",
                     name, id, act, exp);
        end
    endtask

    // Drives one request at the current negedge, records the expectation,
    // then scrambles the operands after acceptance to prove they were latched.
    task automatic applyStimulus(input logic [1:0] opv, input logic [31:0] dv,
                                 input int nv, input logic [31:0] expv,
                                 input int id);
        sb_item_t item;
        start    = 1'b1;
        op       = opv;
        data_in  = dv;
        shamt_in = nv[4:0];
        item.res    = expv;
        item.delta  = expDelta(nv);
        item.accept = cycleCount + 1;
        item.id     = id;
        sbQueue.push_back(item);
        @(negedge clk);
        start    = 1'b0;
        op       = opv ^ 2'b01;
        data_in  = ~dv;
        shamt_in = ~nv[4:0];
    endtask

    // Advances negedge by negedge until done is seen, within a budget.
    task automatic waitForDone(input int budget, input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout (vec %0d): got no done within %0d cycles, expected a done pulse",
                     id, budget);
        end
    endtask

    // Monitor: counts busy cycles and, on every done pulse, pops the oldest
    // expectation and checks result, latency, busy count and exclusivity.
    always @(negedge clk) begin
        sb_item_t item;
        if (reset) begin
            busyCnt = 0;
        end else begin
            if (busy) busyCnt++;
            if (done) begin
                if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done with result 0x%08h, expected no done",
                             result);
                end else begin
                    item = sbQueue.pop_front();
                    checkOutput("result", item.id, result, item.res);
                    checkOutput("latency", item.id, 32'(cycleCount - item.accept),
                                32'(item.delta));
                    checkOutput("busy_cycles", item.id, 32'(busyCnt), 32'(item.delta));
                    checkOutput("busy_with_done", item.id, {31'b0, busy}, 32'd0);
                end
                busyCnt = 0;
            end
        end
    end

    logic [1:0]  tOp  [8];
    logic [31:0] tData[8];
    int          tN   [8];
    logic [31:0] tExp [8];

    // Directed sequence.
    initial begin
        start    = 1'b0;
        op       = 2'b00;
        data_in  = 32'h0;
        shamt_in = 5'd0;
        reset    = 1'b1;

        tOp[0] = 2'b10; tData[0] = 32'h80000000; tN[0] = 31; tExp[0] = 32'hFFFFFFFF;
        tOp[1] = 2'b11; tData[1] = 32'h80000001; tN[1] = 31; tExp[1] = 32'h00000003;
        tOp[2] = 2'b10; tData[2] = 32'h7FFFFFFF; tN[2] = 31; tExp[2] = 32'h00000000;
        tOp[3] = 2'b01; tData[3] = 32'h80000000; tN[3] = 31; tExp[3] = 32'h00000001;
        tOp[4] = 2'b11; tData[4] = 32'h12345678; tN[4] = 4;  tExp[4] = 32'h81234567;
        tOp[5] = 2'b00; tData[5] = 32'hFFFFFFFF; tN[5] = 31; tExp[5] = 32'h80000000;
        tOp[6] = 2'b11; tData[6] = 32'h12345678; tN[6] = 16; tExp[6] = 32'h56781234;
        tOp[7] = 2'b10; tData[7] = 32'h80000000; tN[7] = 5;  tExp[7] = 32'hFC000000;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 0, {31'b0, busy}, 32'd0);
        checkOutput("reset_done", 0, {31'b0, done}, 32'd0);
        checkOutput("reset_result", 0, result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] SRA by 4 and result hold in IDLE");
        applyStimulus(2'b10, 32'h80000000, 4, 32'hF8000000, 1);
        waitForDone(60, 1);
        @(negedge clk);
        op       = 2'b11;
        data_in  = 32'hA5A5A5A5;
        shamt_in = 5'd7;
        repeat (3) @(negedge clk);
        checkOutput("hold_result", 1, result, 32'hF8000000);
        checkOutput("idle_busy", 1, {31'b0, busy}, 32'd0);

        $display("[TB] zero amount");
        applyStimulus(2'b00, 32'h12345678, 0, 32'h12345678, 2);
        waitForDone(60, 2);
        @(negedge clk);

        $display("[TB] ROR by 1 then back-to-back SRL by 31");
        applyStimulus(2'b11, 32'h00000001, 1, 32'h80000000, 3);
        waitForDone(60, 3);
        applyStimulus(2'b01, 32'hFFFFFFFF, 31, 32'h00000001, 4);
        waitForDone(60, 4);
        @(negedge clk);

        $display("[TB] start ignored during SHIFT");
        applyStimulus(2'b00, 32'h000000FF, 8, 32'h0000FF00, 5);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        op       = 2'b01;
        data_in  = 32'hDEADBEEF;
        shamt_in = 5'd3;
        @(negedge clk);
        start    = 1'b0;
        waitForDone(60, 5);
        @(negedge clk);

        $display("[TB] reset in the middle of a shift");
        applyStimulus(2'b01, 32'hF0000000, 10, 32'h000F0000, 6);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sbQueue.delete();
        checkOutput("abort_busy", 6, {31'b0, busy}, 32'd0);
        checkOutput("abort_done", 6, {31'b0, done}, 32'd0);
        checkOutput("abort_result", 6, result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(2'b00, 32'h00000001, 16, 32'h00010000, 7);
        waitForDone(60, 7);
        @(negedge clk);

        $display("[TB] full-range vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tOp[i], tData[i], tN[i], tExp[i], 10 + i);
            waitForDone(60, 10 + i);
            if (i % 2 == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 0, 32'(sbQueue.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
